// File: rtl/ifetch_npc_unit.sv
// ifetch_npc_unit: fetch-side companion to the PC register in the multi-cycle MIPS core.
// It fetches the instruction at PC into IR, computes NPC[31:2] and pulses PCWr.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   PC                  current instruction word address [31:2]
//   fetch_req           start a fetch at PC (IDLE only)
//   im_rd, im_addr      instruction-memory read request and word address
//   im_ready, im_dout   memory data valid strobe and instruction word
//   IR, ir_valid        latched instruction and one-cycle update pulse
//   npc_req, npc_sel    PC update request; 00 seq, 01 branch, 10 jump, 11 jr
//   br_taken, rs_data   branch condition and jr target register
//   NPC, PCWr           next PC [31:2] and one-cycle PC write enable
//   busy, fetch_err     fetch in progress, sticky timeout flag
module ifetch_npc_unit #(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter logic [29:0] RESET_NPC     = 30'h0C00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] PC,
    input  logic        fetch_req,
    output logic        im_rd,
    output logic [29:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_dout,
    output logic [31:0] IR,
    output logic        ir_valid,
    input  logic        npc_req,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] rs_data,
    output logic [29:0] NPC,
    output logic        PCWr,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state;
    logic [29:0] pc_q;
    logic [7:0]  cnt;

    logic [29:0] p1;
    logic [29:0] boff;
    logic [29:0] npc_next;

    // jr targets are word aligned; the low two bits carry no information
    logic unused_rs_lo;
    assign unused_rs_lo = ^rs_data[1:0];

    always_comb begin
        p1       = pc_q + 30'd1;
        boff     = {{14{IR[15]}}, IR[15:0]};
        npc_next = p1;
        unique case (npc_sel)
            2'b00: npc_next = p1;
            2'b01: npc_next = br_taken ? (p1 + boff) : p1;
            2'b10: npc_next = {p1[29:26], IR[25:0]};
            2'b11: npc_next = rs_data[31:2];
            default: npc_next = p1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_NPC;
            cnt       <= 8'd0;
            im_rd     <= 1'b0;
            im_addr   <= 30'd0;
            IR        <= 32'd0;
            ir_valid  <= 1'b0;
            NPC       <= RESET_NPC;
            PCWr      <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            PCWr     <= 1'b0;

            // npc_next reads the old pc_q/IR even when a fetch starts now
            if (state == IDLE && npc_req) begin
                NPC  <= npc_next;
                PCWr <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fetch_req) begin
                        pc_q    <= PC;
                        im_addr <= PC;
                        im_rd   <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= 8'd0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    // a response on the last allowed cycle still completes
                    if (im_ready) begin
                        IR       <= im_dout;
                        ir_valid <= 1'b1;
                        im_rd    <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        im_rd     <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_npc_unit.sv
// tb_ifetch_npc_unit: self-checking bench for ifetch_npc_unit.
// Table-driven NPC vectors plus hand-written fetch/timeout/reset sequences.
module tb_ifetch_npc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PC;
    logic        fetch_req;
    logic        im_rd;
    logic [29:0] im_addr;
    logic        im_ready;
    logic [31:0] im_dout;
    logic [31:0] IR;
    logic        ir_valid;
    logic        npc_req;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] rs_data;
    logic [29:0] NPC;
    logic        PCWr;
    logic        busy;
    logic        fetch_err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_ir_q[$];
    logic [29:0] exp_npc_q[$];
    logic        pcwr_prev = 1'b0;

    always #5 clk = ~clk;

    ifetch_npc_unit #(
        .FETCH_TIMEOUT(16),
        .RESET_NPC(30'h0C00)
    ) dut (
        .clk(clk), .rst(rst), .PC(PC), .fetch_req(fetch_req),
        .im_rd(im_rd), .im_addr(im_addr), .im_ready(im_ready),
        .im_dout(im_dout), .IR(IR), .ir_valid(ir_valid),
        .npc_req(npc_req), .npc_sel(npc_sel), .br_taken(br_taken),
        .rs_data(rs_data), .NPC(NPC), .PCWr(PCWr), .busy(busy),
        .fetch_err(fetch_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: IR and NPC expectations popped when the DUT pulses
    always @(negedge clk) begin
        if (ir_valid) begin
            if (exp_ir_q.size() == 0) check("unexpected ir_valid", 32'd1, 32'd0);
            else check("ir", IR, exp_ir_q.pop_front());
        end
        if (PCWr) begin
            if (exp_npc_q.size() == 0) check("unexpected PCWr", 32'd1, 32'd0);
            else check("npc", {2'b0, NPC}, {2'b0, exp_npc_q.pop_front()});
            if (pcwr_prev) check("pcwr two cycles", 32'd1, 32'd0);
        end
        pcwr_prev = PCWr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // fetch with im_ready on the cycle after fetch_req (minimum latency)
    task automatic fetch(input logic [29:0] pc, input logic [31:0] d);
        PC        = pc;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("im_rd in fetch", {31'b0, im_rd}, 32'd1);
        check("im_addr", {2'b0, im_addr}, {2'b0, pc});
        im_ready = 1'b1;
        im_dout  = d;
        exp_ir_q.push_back(d);
        step();
        im_ready = 1'b0;
        check("ir_valid latency", {31'b0, ir_valid}, 32'd1);
        check("busy after fetch", {31'b0, busy}, 32'd0);
        step();
        check("ir_valid one cycle", {31'b0, ir_valid}, 32'd0);
    endtask

    task automatic npc(input logic [1:0] sel, input logic br,
                       input logic [31:0] rs, input logic [29:0] exp);
        npc_req  = 1'b1;
        npc_sel  = sel;
        br_taken = br;
        rs_data  = rs;
        exp_npc_q.push_back(exp);
        step();
        npc_req = 1'b0;
        check("pcwr pulse", {31'b0, PCWr}, 32'd1);
        step();
        check("pcwr cleared", {31'b0, PCWr}, 32'd0);
    endtask

    typedef struct {
        logic [29:0] pc;
        logic [31:0] ir;
        logic [1:0]  sel;
        logic        br;
        logic [31:0] rs;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{30'h0C00, 32'h2008_0005, 2'b00, 1'b0, 32'h0, 30'h0C01};
        vecs[1] = '{30'h0C00, 32'h1000_FFFE, 2'b01, 1'b1, 32'h0, 30'h0BFF};
        vecs[2] = '{30'h0C00, 32'h1000_FFFE, 2'b01, 1'b0, 32'h0, 30'h0C01};
        vecs[3] = '{30'h0C00, 32'h0800_0C10, 2'b10, 1'b0, 32'h0, 30'h0C10};
        vecs[4] = '{30'h0C00, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_301F, 30'h0C07};
        vecs[5] = '{30'h3FFF_FFFF, 32'h0800_0001, 2'b10, 1'b0, 32'h0, 30'h0000_0001};

        rst = 1'b1; PC = '0; fetch_req = 0; im_ready = 0; im_dout = '0;
        npc_req = 0; npc_sel = '0; br_taken = 0; rs_data = '0;
        step();
        step();
        rst = 1'b0;
        check("rst im_rd", {31'b0, im_rd}, 32'd0);
        check("rst im_addr", {2'b0, im_addr}, 32'd0);
        check("rst IR", IR, 32'd0);
        check("rst ir_valid", {31'b0, ir_valid}, 32'd0);
        check("rst NPC", {2'b0, NPC}, 32'h0000_0C00);
        check("rst PCWr", {31'b0, PCWr}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst fetch_err", {31'b0, fetch_err}, 32'd0);

        // fetch then NPC modes
        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].pc, vecs[i].ir);
            npc(vecs[i].sel, vecs[i].br, vecs[i].rs, vecs[i].exp);
        end

        // timeout: im_ready never comes
        fetch(30'h0C00, 32'hAAAA_5555);
        PC = 30'h0C20;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (im_rd && n < 40) begin
            n++;
            step();
        end
        check("timeout im_rd cycles", n, 32'd16);
        check("timeout fetch_err", {31'b0, fetch_err}, 32'd1);
        check("timeout IR kept", IR, 32'hAAAA_5555);
        check("timeout busy", {31'b0, busy}, 32'd0);
        repeat (3) step();
        check("fetch_err sticky", {31'b0, fetch_err}, 32'd1);
        do_reset();
        check("fetch_err cleared", {31'b0, fetch_err}, 32'd0);

        // im_ready on the last allowed cycle wins
        PC = 30'h0C30;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        repeat (15) step();
        check("late im_rd", {31'b0, im_rd}, 32'd1);
        im_ready = 1'b1;
        im_dout  = 32'h1234_5678;
        exp_ir_q.push_back(32'h1234_5678);
        step();
        im_ready = 1'b0;
        check("late ir_valid", {31'b0, ir_valid}, 32'd1);
        check("late no err", {31'b0, fetch_err}, 32'd0);

        // fetch_req and npc_req together: old pc_q, pre-update PC
        fetch(30'h0C00, 32'h2008_0005);
        PC = 30'h0C05;
        fetch_req = 1'b1;
        npc_req = 1'b1;
        npc_sel = 2'b00;
        exp_npc_q.push_back(30'h0C01);
        step();
        fetch_req = 1'b0;
        npc_req = 1'b0;
        check("joint PCWr", {31'b0, PCWr}, 32'd1);
        check("joint im_addr", {2'b0, im_addr}, 32'h0000_0C05);
        // npc_req during FETCH is dropped
        npc_req = 1'b1;
        step();
        npc_req = 1'b0;
        check("fetch npc ignored", {31'b0, PCWr}, 32'd0);
        im_ready = 1'b1;
        im_dout = 32'h0000_0001;
        exp_ir_q.push_back(32'h0000_0001);
        step();
        im_ready = 1'b0;
        check("joint NPC held", {2'b0, NPC}, 32'h0000_0C01);
        npc(2'b00, 1'b0, 32'h0, 30'h0C06);

        // reset in the third FETCH cycle
        PC = 30'h0C40;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst im_rd", {31'b0, im_rd}, 32'd0);
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst NPC", {2'b0, NPC}, 32'h0000_0C00);
        im_ready = 1'b1;
        im_dout = 32'hDEAD_BEEF;
        step();
        im_ready = 1'b0;
        step();
        check("midrst IR", IR, 32'd0);

        check("ir queue drained", exp_ir_q.size(), 32'd0);
        check("npc queue drained", exp_npc_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
